phase_scheduler: RTL

//  Sequences the traffic-light fsm: owns the phase timer and the demand-to-table selection.

---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/tick_prescaler.sv | 34 +++
 rtl/phase_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light controller slice.
//  table_e       : timing-table codes presented to the fsm (A..D)
//  light_e       : lamp drive codes
//  sched_state_e : phase_scheduler state encoding
//  sel_table()   : maps the latched demand vector {STH,SNN,SNS} to a table
package traffic_pkg;

  typedef enum logic [1:0] {
    TBL_A = 2'b00,
    TBL_B = 2'b01,
    TBL_C = 2'b10,
    TBL_D = 2'b11
  } table_e;

  typedef enum logic [1:0] {
    LT_RED    = 2'b00,
    LT_YELLOW = 2'b01,
    LT_GREEN  = 2'b10,
    LT_OFF    = 2'b11
  } light_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_KICK = 2'b01,
    ST_LOAD = 2'b10,
    ST_RUN  = 2'b11
  } sched_state_e;

  // Exactly one demand picks its dedicated table; none or a conflict
  // falls back to the default table A.
  function automatic table_e sel_table(input logic [2:0] dem);
    case (dem)
      3'b100:  sel_table = TBL_B;
      3'b010:  sel_table = TBL_C;
      3'b001:  sel_table = TBL_D;
      default: sel_table = TBL_A;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator for the phase scheduler.
//  clk   in  system clock
//  reset in  async active-low reset
//  run   in  count enable; counter is held at 0 while low
//  tick  out one-cycle pulse when the counter wraps at CLK_HZ-1
module tick_prescaler #(
  parameter int CLK_HZ = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int              CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  // Holding at 0 outside run makes the first tick land exactly CLK_HZ
  // cycles after run rises.
  always_comb begin
    cnt_d = '0;
    if (run && !tick) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phase_scheduler.sv
// Phase timer and demand-to-table selector for the traffic-light fsm.
//  clk, reset        system clock; async active-low reset
//  enable_general    low forces IDLE (demands are kept)
//  SNN, SNS, STH     raw vehicle sensors (async, synchronized here)
//  ped_req           raw pedestrian button (used only with PED_EXTEND_EN)
//  secondsToCount    phase duration from the fsm, sampled in LOAD
//  finished          one-cycle pulse, phase over
//  tabla             timing table for the next phase
//  seconds_left      remaining seconds of the current phase
//  busy              high in LOAD and RUN
// Build option: define PED_EXTEND_EN to extend the next phase by PED_EXTRA
// seconds after a pedestrian request.
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CLK_HZ      = 10000,
  parameter int MIN_SECONDS = 1,
  parameter int PED_EXTRA   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_general,
  input  logic        SNN,
  input  logic        SNS,
  input  logic        STH,
  input  logic        ped_req,
  input  logic [15:0] secondsToCount,
  output logic        finished,
  output logic [1:0]  tabla,
  output logic [15:0] seconds_left,
  output logic        busy
);

  localparam logic [15:0] MIN16 = 16'(MIN_SECONDS);

  sched_state_e state_q, state_d;
  table_e       tabla_q, tabla_d;
  logic [15:0]  sl_q, sl_d;
  logic [2:0]   snc1_q, snc2_q;     // {STH,SNN,SNS}
  logic [2:0]   dem_q, dem_d;
  logic [15:0]  base_sec, load_sec;
  logic         tick;

  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == ST_RUN),
    .tick  (tick)
  );

  assign base_sec = (secondsToCount < MIN16) ? MIN16 : secondsToCount;

`ifdef PED_EXTEND_EN
  logic        ped1_q, ped2_q, ped_q, ped_d;
  // Request captured at KICK, consumed by the following LOAD.
  logic        ped_ext_q, ped_ext_d;
  logic [16:0] ext_sum;

  assign ext_sum  = {1'b0, base_sec} + 17'(PED_EXTRA);
  assign load_sec = !ped_ext_q ? base_sec :
                    ext_sum[16] ? 16'hFFFF : ext_sum[15:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped1_q    <= 1'b0;
      ped2_q    <= 1'b0;
      ped_q     <= 1'b0;
      ped_ext_q <= 1'b0;
    end else begin
      ped1_q    <= ped_req;
      ped2_q    <= ped1_q;
      ped_q     <= ped_d;
      ped_ext_q <= ped_ext_d;
    end
  end
`else
  logic ped_unused;
  assign ped_unused = ped_req;
  assign load_sec   = base_sec;
`endif

  always_comb begin
    state_d = state_q;
    tabla_d = tabla_q;
    sl_d    = sl_q;
    dem_d   = dem_q | snc2_q;
`ifdef PED_EXTEND_EN
    ped_d     = ped_q | ped2_q;
    ped_ext_d = ped_ext_q;
`endif
    if (!enable_general) begin
      state_d = ST_IDLE;
      sl_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_KICK;
        ST_KICK: begin
          tabla_d = sel_table(dem_q);
          // Clear, but keep anything sampled this same cycle.
          dem_d   = snc2_q;
`ifdef PED_EXTEND_EN
          ped_ext_d = ped_q;
          ped_d     = ped2_q;
`endif
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          sl_d    = load_sec;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            if (sl_q <= 16'd1) begin
              sl_d    = '0;
              state_d = ST_KICK;
            end else begin
              sl_d = sl_q - 16'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tabla_q <= TBL_A;
      sl_q    <= '0;
      snc1_q  <= '0;
      snc2_q  <= '0;
      dem_q   <= '0;
    end else begin
      state_q <= state_d;
      tabla_q <= tabla_d;
      sl_q    <= sl_d;
      snc1_q  <= {STH, SNN, SNS};
      snc2_q  <= snc1_q;
      dem_q   <= dem_d;
    end
  end

  // During the pulse the fsm already sees the table chosen for the next phase.
  assign finished     = (state_q == ST_KICK);
  assign tabla        = (state_q == ST_KICK) ? sel_table(dem_q) : tabla_q;
  assign seconds_left = sl_q;
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_RUN);

endmodule
